// File: rtl/mod_n_down_counter.sv
// Programmable modulo-MOD down counter with auto-reload or one-shot expiry,
// a combinational terminal-count strobe for borrow-chain cascading, and a sticky done flag.
module mod_n_down_counter #(
    parameter int unsigned MOD   = 6,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

    logic             at_zero;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_next;
    logic             done_next;

    always_comb begin
        at_zero      = (count == '0);
        load_clamped = (load_val > MAX) ? MAX : load_val;
        // Borrow-out only on a real wrap/expiry decision; a load pre-empts it.
        tc           = en & ~load & ~done & at_zero;
    end

    always_comb begin
        count_next = count;
        done_next  = done;
        if (load) begin
            count_next = load_clamped;
            done_next  = 1'b0;
        end else if (en && !done) begin
            if (!at_zero) begin
                count_next = count - WIDTH'(1);
            end else if (auto_reload) begin
                count_next = MAX;
            end else begin
                done_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= MAX;
            done  <= 1'b0;
        end else begin
            count <= count_next;
            done  <= done_next;
        end
    end

endmodule

// File: tb/tb_mod_n_down_counter.sv
// Directed self-checking bench for mod_n_down_counter (MOD=6): reset, auto-reload,
// one-shot, load/clamp, enable gating and a two-stage borrow cascade.
module tb_mod_n_down_counter;

    logic       clk = 1'b0;
    logic       clr;
    logic       en;
    logic       load;
    logic [2:0] load_val;
    logic       auto_reload;
    logic [2:0] count;
    logic       tc;
    logic       done;

    logic       cas_en;
    logic [2:0] cas_zero_val;
    logic       cas_zero;
    logic       cas_reload;
    logic [2:0] cas_count1;
    logic       cas_tc1;
    logic       cas_done1;
    logic [2:0] cas_count2;
    logic       cas_tc2;
    logic       cas_done2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_n_down_counter #(.MOD(6), .WIDTH(3)) u_dut (
        .clk(clk), .clr(clr), .en(en), .load(load), .load_val(load_val),
        .auto_reload(auto_reload), .count(count), .tc(tc), .done(done)
    );

    mod_n_down_counter #(.MOD(6), .WIDTH(3)) u_stage1 (
        .clk(clk), .clr(clr), .en(cas_en), .load(cas_zero), .load_val(cas_zero_val),
        .auto_reload(cas_reload), .count(cas_count1), .tc(cas_tc1), .done(cas_done1)
    );

    mod_n_down_counter #(.MOD(6), .WIDTH(3)) u_stage2 (
        .clk(clk), .clr(clr), .en(cas_tc1), .load(cas_zero), .load_val(cas_zero_val),
        .auto_reload(cas_reload), .count(cas_count2), .tc(cas_tc2), .done(cas_done2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        clr = 1'b0; en = 1'b0; load = 1'b0; load_val = 3'd0; auto_reload = 1'b1;
        #2 clr = 1'b1;
        tick; tick;
        checks++; if (count !== 3'd5) begin errors++; $display("FAIL reset_init: count=%0d expected 5", count); end
        clr = 1'b0; en = 1'b1;
        tick; tick;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL reset_precount: count=%0d expected 3", count); end
        #3 clr = 1'b1;
        #1;
        checks++; if (count !== 3'd5) begin errors++; $display("FAIL reset_async_count: count=%0d expected 5", count); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_async_done: done=%0b expected 0", done); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc: tc=%0b expected 0", tc); end
        load = 1'b1; load_val = 3'd2;
        tick;
        checks++; if (count !== 3'd5) begin errors++; $display("FAIL reset_hold: count=%0d expected 5", count); end
        clr = 1'b0; load = 1'b0; en = 1'b0;
        tick;
        checks++; if (count !== 3'd5) begin errors++; $display("FAIL reset_release: count=%0d expected 5", count); end
    endtask

    task automatic test_auto_reload;
        logic [2:0] exp_cnt;
        auto_reload = 1'b1; en = 1'b1;
        #1;
        for (int i = 0; i < 13; i++) begin
            exp_cnt = 3'(5 - (i % 6));
            checks++; if (count !== exp_cnt) begin errors++; $display("FAIL auto_count[%0d]: count=%0d expected %0d", i, count, exp_cnt); end
            checks++; if (tc !== (exp_cnt == 3'd0)) begin errors++; $display("FAIL auto_tc[%0d]: tc=%0b expected %0b", i, tc, exp_cnt == 3'd0); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL auto_done[%0d]: done=%0b expected 0", i, done); end
            tick;
        end
        en = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL auto_end: count=%0d expected 4", count); end
    endtask

    task automatic test_one_shot;
        logic [2:0] exp_cnt [6];
        logic       exp_tc  [6];
        logic       exp_dn  [6];
        exp_cnt = '{3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
        exp_tc  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_dn  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        load = 1'b1; load_val = 3'd2;
        tick;
        load = 1'b0; auto_reload = 1'b0; en = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            // Flip to auto-reload in the last cycle: expiry must stay latched.
            if (i == 5) begin auto_reload = 1'b1; #1; end
            checks++; if (count !== exp_cnt[i]) begin errors++; $display("FAIL oneshot_count[%0d]: count=%0d expected %0d", i, count, exp_cnt[i]); end
            checks++; if (tc !== exp_tc[i]) begin errors++; $display("FAIL oneshot_tc[%0d]: tc=%0b expected %0b", i, tc, exp_tc[i]); end
            checks++; if (done !== exp_dn[i]) begin errors++; $display("FAIL oneshot_done[%0d]: done=%0b expected %0b", i, done, exp_dn[i]); end
            tick;
        end
        checks++; if (count !== 3'd0 || done !== 1'b1) begin errors++; $display("FAIL oneshot_stuck: count=%0d done=%0b expected 0/1", count, done); end
    endtask

    task automatic test_load;
        // count=0, done=1, en=1, auto_reload=1 on entry
        load = 1'b1; load_val = 3'd3;
        #1;
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL load_tc_done: tc=%0b expected 0", tc); end
        tick;
        checks++; if (count !== 3'd3 || done !== 1'b0) begin errors++; $display("FAIL load_clear: count=%0d done=%0b expected 3/0", count, done); end
        load = 1'b0;
        tick; tick; tick;
        checks++; if (count !== 3'd0 || tc !== 1'b1) begin errors++; $display("FAIL load_reach0: count=%0d tc=%0b expected 0/1", count, tc); end
        load = 1'b1; load_val = 3'd3;
        #1;
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL load_wins_tc: tc=%0b expected 0", tc); end
        tick;
        checks++; if (count !== 3'd3 || done !== 1'b0) begin errors++; $display("FAIL load_wins: count=%0d done=%0b expected 3/0", count, done); end
        en = 1'b0; load_val = 3'd7;
        tick;
        checks++; if (count !== 3'd5) begin errors++; $display("FAIL load_clamp7: count=%0d expected 5", count); end
        load_val = 3'd6;
        tick;
        checks++; if (count !== 3'd5) begin errors++; $display("FAIL load_clamp6: count=%0d expected 5", count); end
        load_val = 3'd0;
        tick;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL load_zero: count=%0d expected 0", count); end
        load_val = 3'd5;
        tick;
        checks++; if (count !== 3'd5) begin errors++; $display("FAIL load_max: count=%0d expected 5", count); end
        load = 1'b0;
    endtask

    task automatic test_enable_gating;
        logic       en_seq  [4];
        logic [2:0] exp_cnt [4];
        en_seq  = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_cnt = '{3'd4, 3'd4, 3'd3, 3'd3};
        for (int i = 0; i < 4; i++) begin
            en = en_seq[i];
            tick;
            checks++; if (count !== exp_cnt[i]) begin errors++; $display("FAIL gate_count[%0d]: count=%0d expected %0d", i, count, exp_cnt[i]); end
        end
        load = 1'b1; load_val = 3'd0; en = 1'b0;
        tick;
        load = 1'b0;
        #1;
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL gate_tc_idle: tc=%0b expected 0", tc); end
        tick;
        checks++; if (count !== 3'd0 || tc !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL gate_hold0: count=%0d tc=%0b done=%0b expected 0/0/0", count, tc, done); end
        en = 1'b1;
        #1;
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL gate_tc_en: tc=%0b expected 1", tc); end
        en = 1'b0;
    endtask

    task automatic test_cascade;
        logic [2:0] exp1;
        logic [2:0] exp2;
        int         wraps;
        wraps = 0;
        cas_en = 1'b1;
        #1;
        for (int k = 0; k < 36; k++) begin
            exp1 = 3'(5 - (k % 6));
            exp2 = 3'(5 - ((k / 6) % 6));
            checks++; if (cas_count1 !== exp1) begin errors++; $display("FAIL cas_count1[%0d]: count=%0d expected %0d", k, cas_count1, exp1); end
            checks++; if (cas_count2 !== exp2) begin errors++; $display("FAIL cas_count2[%0d]: count=%0d expected %0d", k, cas_count2, exp2); end
            checks++; if ((cas_tc1 & cas_tc2) !== (k == 35)) begin errors++; $display("FAIL cas_wrap[%0d]: wrap=%0b expected %0b", k, cas_tc1 & cas_tc2, k == 35); end
            if (cas_tc1 & cas_tc2) wraps++;
            tick;
        end
        cas_en = 1'b0;
        checks++; if (wraps != 1) begin errors++; $display("FAIL cas_wrap_count: wraps=%0d expected 1", wraps); end
        checks++; if (cas_count1 !== 3'd5 || cas_count2 !== 3'd5) begin errors++; $display("FAIL cas_end: counts=%0d/%0d expected 5/5", cas_count1, cas_count2); end
    endtask

    initial begin
        cas_en = 1'b0; cas_zero = 1'b0; cas_zero_val = 3'd0; cas_reload = 1'b1;
        test_reset;
        test_auto_reload;
        test_one_shot;
        test_load;
        test_enable_gating;
        test_cascade;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mod_n_down_counter.md
Name: mod_n_down_counter

Overview:
- Synchronous, programmable modulo-N down counter. It is the count-down counterpart of the team's mod-6 ripple up-counter.
- Counts MOD-1 down to 0. It then either wraps back to MOD-1 (auto-reload) or halts at 0 with a sticky done flag (one-shot).
- Provides a terminal-count strobe, so instances can be cascaded as borrow chains or used as timeout/divider blocks.

Parameters:
- MOD, 6, modulus; count range 0..MOD-1; legal MOD >= 2.
- WIDTH, 3, count width; must satisfy 2**WIDTH >= MOD.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- clr  input  1  reset, asynchronous, active-high.
- en  input  1  count enable; decrement by 1 per enabled cycle.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value to load.
- auto_reload  input  1  1 = wrap 0 -> MOD-1; 0 = one-shot, halt at 0.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal count / borrow-out, combinational.
- done  output  1  one-shot expiry flag, registered, sticky.

Behaviour:
- Reset: clr=1 forces count=MOD-1 and done=0 immediately, without waiting for clk. While clr is held, load and en are ignored. Counting resumes on the first rising edge after clr deasserts.
- Next-state priority, per rising edge:
  1. load=1: count <= min(load_val, MOD-1). Out-of-range load_val clamps to MOD-1. Sets done <= 0. en is ignored this cycle.
  2. en=1, done=0, count!=0: count <= count-1.
  3. en=1, done=0, count==0, auto_reload=1: count <= MOD-1; done stays 0.
  4. en=1, done=0, count==0, auto_reload=0: count holds 0; done <= 1.
  5. Otherwise (en=0, or done=1 without load): hold count and done.
- tc = en & ~load & ~done & (count==0).
  - Zero latency; asserts in the same cycle as the wrap/expiry decision. Width is one enabled cycle per pass.
  - Cascading: the next stage's en is driven from tc.
- done:
  - Rises one clock after the enabled cycle at count==0 in one-shot mode.
  - Cleared only by load or clr.
  - While done=1, tc=0 and count stays 0 regardless of en.
- auto_reload changes take effect at the next count==0 decision. Switching 0 -> 1 while done=1 does not restart counting; a load is required.
- Period: auto-reload with en held high gives tc once every MOD cycles. Divide-by-MOD is exact, including for MOD not a power of two.
- All arithmetic is unsigned WIDTH bits. No state ever reaches a value >= MOD.
- Simultaneous load & en at count==0: load wins, tc=0, done cleared.
- Reset mid-count: the async clear overrides any in-flight load or decrement.

Test Plan:
- Reset: MOD=6; assert clr between clock edges -> count=5, done=0 before the next edge; tc=0 while clr is high.
- Auto-reload: MOD=6, auto_reload=1, en high for 13 cycles -> count sequence 5,4,3,2,1,0,5,4,3,2,1,0,5; tc high exactly in the two cycles where count=0; done stays 0.
- One-shot: auto_reload=0, en high from count=2 -> 2,1,0,0,...; tc high for one cycle at the first count=0; done=1 from the next cycle onward; further en gives no tc and count remains 0.
- Load:
  - load_val=3 with en=1 at count=0 -> next count=3, tc=0 that cycle, done cleared.
  - load_val=7 (MOD=6) -> count=5 (clamped).
- Enable gating: en toggled 1,0,1,0 starting from 5 -> count 4,4,3,3; tc never asserted while en=0 at count=0.
- Cascade: two instances (MOD=6 each), stage-2 en driven by stage-1 tc, en high for 36 cycles -> stage 2 decrements every 6 cycles; a combined wrap (both counts 0 with both tc high) occurs once every 36 cycles.
